// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions for the fetch stage.
// Holds the FSM encoding, reset/timeout defaults and PC arithmetic helpers.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned TIMEOUT_DEFAULT  = 16;
  localparam int unsigned TMO_CNT_W        = 5;

  // Word offset of a branch immediate, already scaled to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] idx);
    return {region, idx, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Combinational next-PC selection: jump, taken branch or sequential.
module next_pc_sel
  import instr_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4_i,
  input  logic [25:0] instr_i,
  input  logic        branch_i,
  input  logic        mux_pc_branch_i,
  input  logic        mux_branch_jump_i,
  input  logic        alu_zero_i,
  output logic [31:0] next_pc_o
);

  // Jump outranks branch; a branch needs all three qualifiers.
  always_comb begin
    next_pc_o = pc_plus4_i;
    if (!mux_branch_jump_i) begin
      next_pc_o = jump_target(pc_plus4_i[31:28], instr_i);
    end else if (branch_i && mux_pc_branch_i && alu_zero_i) begin
      next_pc_o = pc_plus4_i + branch_offset(instr_i[15:0]);
    end else begin
      next_pc_o = pc_plus4_i;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word at pc, holds it for decode,
// and steps pc once the datapath signals advance. Stalled fetches latch an error.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        advance,
  input  logic        branch,
  input  logic        mux_pc_branch,
  input  logic        mux_branch_jump,
  input  logic        alu_zero,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [31:0]          instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 req_q, req_d;
  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          pc_plus4_s;
  logic [31:0]          next_pc_s;

  assign pc_plus4_s = pc_q + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4_i        (pc_plus4_s),
    .instr_i           (instr_q[25:0]),
    .branch_i          (branch),
    .mux_pc_branch_i   (mux_pc_branch),
    .mux_branch_jump_i (mux_branch_jump),
    .alu_zero_i        (alu_zero),
    .next_pc_o         (next_pc_s)
  );

  // Next-state and datapath-register update for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          cnt_d   = {TMO_CNT_W{1'b0}};
          state_d = ST_HOLD;
        end else if (cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end else begin
          cnt_d   = cnt_q + {{(TMO_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HOLD: begin
        if (advance) begin
          pc_d    = {next_pc_s[31:2], 2'b00};
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_ERROR: begin
        valid_d = 1'b0;
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Request is registered so it is high exactly while the FSM sits in FETCH.
    req_d = (state_d == ST_FETCH);
  end

  // State and output registers; reset wins over a same-cycle ack.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= 32'h0000_0000;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      cnt_q   <= {TMO_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, random
// instruction stream against a PC reference model, and reset/timeout sequences.
module tb_instr_fetch;

  logic        clk;
  logic        nrst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        advance;
  logic        branch;
  logic        mux_pc_branch;
  logic        mux_branch_jump;
  logic        alu_zero;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] cur_pc;

  typedef struct {
    logic [31:0] word;
    int          waits;
    logic        br;
    logic        mpb;
    logic        mbj;
    logic        az;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [13];

  instr_fetch dut (
    .clk             (clk),
    .nrst            (nrst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .advance         (advance),
    .branch          (branch),
    .mux_pc_branch   (mux_pc_branch),
    .mux_branch_jump (mux_branch_jump),
    .alu_zero        (alu_zero),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .fetch_err       (fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC from the architectural rules, plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic br, input logic mpb,
                                           input logic mbj, input logic az);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (!mbj) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (br && mpb && az) begin
      off = int'($signed(word[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // One complete fetch/hold/advance transaction starting from FETCH (or IDLE).
  task automatic do_instr(input string tag, input logic [31:0] word, input int waits,
                          input logic br, input logic mpb, input logic mbj,
                          input logic az, input logic [31:0] exp_next);
    for (int i = 0; i < 4 && imem_req !== 1'b1; i++) step();
    chk({tag, " req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, " addr"}, imem_addr, cur_pc);
    for (int i = 0; i < waits; i++) begin
      advance  = 1'b1;
      imem_ack = 1'b0;
      step();
      chk({tag, " wait pc"}, pc, cur_pc);
      chk({tag, " wait valid"}, {31'd0, instr_valid}, 32'd0);
      chk({tag, " wait req"}, {31'd0, imem_req}, 32'd1);
    end
    advance    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_rdata      = ~word;
    branch          = 1'($urandom);
    mux_pc_branch   = 1'($urandom);
    mux_branch_jump = 1'($urandom);
    alu_zero        = 1'($urandom);
    chk({tag, " valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " instr"}, instr, word);
    chk({tag, " pc_plus4"}, pc_plus4, cur_pc + 32'd4);
    chk({tag, " hold req"}, {31'd0, imem_req}, 32'd0);
    step();
    chk({tag, " hold instr"}, instr, word);
    chk({tag, " hold valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, " hold pc"}, pc, cur_pc);
    imem_ack        = 1'b0;
    advance         = 1'b1;
    branch          = br;
    mux_pc_branch   = mpb;
    mux_branch_jump = mbj;
    alu_zero        = az;
    step();
    advance = 1'b0;
    chk({tag, " adv valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, " next pc"}, pc, exp_next);
    cur_pc = exp_next;
  endtask

  initial begin
    logic [31:0] w;
    logic        rb, rp, rj, rz;
    clk = 1'b0; nrst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
    branch = 1'b0; mux_pc_branch = 1'b0; mux_branch_jump = 1'b1; alu_zero = 1'b0;

    vecs[0]  = '{32'h2009_0001, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008};
    vecs[1]  = '{32'h2129_0002, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_000C};
    vecs[2]  = '{32'h1000_0005, 3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
    vecs[3]  = '{32'h1000_FFFE, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_000C};
    vecs[4]  = '{32'h0000_0020, 2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010};
    vecs[5]  = '{32'h1000_FFFE, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0014};
    vecs[6]  = '{32'h0800_0000, 0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7]  = '{32'h1000_FFFE, 2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC};
    vecs[8]  = '{32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[9]  = '{32'h0BFF_FFFF, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0FFF_FFFC};
    vecs[10] = '{32'h0000_0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1000_0000};
    vecs[11] = '{32'h0800_0040, 1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1000_0100};
    vecs[12] = '{32'h1000_0010, 0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1000_0144};

    // Reset state
    step(); step();
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst valid", {31'd0, instr_valid}, 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst pc", pc, 32'h0);
    chk("rst err", {31'd0, fetch_err}, 32'd0);
    chk("rst pc_plus4", pc_plus4, 32'h4);

    // First fetch: two wait cycles, valid on cycle 4 after release
    nrst = 1'b1;
    step();
    chk("c1 req", {31'd0, imem_req}, 32'd1);
    chk("c1 addr", imem_addr, 32'h0);
    step();
    step();
    chk("c3 valid", {31'd0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    step();
    imem_ack = 1'b0;
    chk("c4 valid", {31'd0, instr_valid}, 32'd1);
    chk("c4 instr", instr, 32'h2008_0005);
    advance = 1'b1; branch = 1'b0; mux_branch_jump = 1'b1;
    step();
    advance = 1'b0;
    chk("first adv pc", pc, 32'h4);
    cur_pc = 32'h4;

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      do_instr($sformatf("vec%0d", i), vecs[i].word, vecs[i].waits, vecs[i].br,
               vecs[i].mpb, vecs[i].mbj, vecs[i].az, vecs[i].exp_pc);
    end

    // Random instruction stream against the reference model
    for (int i = 0; i < 40; i++) begin
      w  = $urandom;
      rb = 1'($urandom);
      rp = 1'($urandom);
      rz = 1'($urandom);
      rj = ($urandom_range(0, 3) != 0);
      do_instr($sformatf("rnd%0d", i), w, $urandom_range(0, 4), rb, rp, rj, rz,
               ref_next(cur_pc, w, rb, rp, rj, rz));
    end

    // Reset mid-FETCH with a simultaneous ack
    nrst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("rst2 pc", pc, 32'h0);
    chk("rst2 instr", instr, 32'h0);
    chk("rst2 req", {31'd0, imem_req}, 32'd0);
    nrst = 1'b1; imem_ack = 1'b0;
    step();
    chk("rst3 req", {31'd0, imem_req}, 32'd1);
    nrst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    step();
    chk("rst3 instr", instr, 32'h0);
    chk("rst3 valid", {31'd0, instr_valid}, 32'd0);
    chk("rst3 req drop", {31'd0, imem_req}, 32'd0);

    // Fetch timeout: 16 FETCH cycles without ack
    imem_ack = 1'b0; nrst = 1'b1;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo pre err", {31'd0, fetch_err}, 32'd0);
    chk("tmo pre req", {31'd0, imem_req}, 32'd1);
    step();
    chk("tmo err", {31'd0, fetch_err}, 32'd1);
    chk("tmo req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; advance = 1'b1;
    step(); step(); step();
    imem_ack = 1'b0; advance = 1'b0;
    chk("err late ack valid", {31'd0, instr_valid}, 32'd0);
    chk("err late ack instr", instr, 32'h0);
    chk("err sticky", {31'd0, fetch_err}, 32'd1);
    chk("err req", {31'd0, imem_req}, 32'd0);
    nrst = 1'b0;
    step();
    chk("err clr", {31'd0, fetch_err}, 32'd0);
    chk("err clr pc", pc, 32'h0);
    nrst = 1'b1;
    step();
    chk("recover req", {31'd0, imem_req}, 32'd1);
    chk("recover addr", imem_addr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, 16, FETCH cycles without imem_ack before fetch error.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  32  read address, equal to pc.
REQ-007 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  32  instruction word.
REQ-009 SHALL have port instr  output  32  latched instruction; opcode instr[31:26] feeds the control decoder.
REQ-010 SHALL have port instr_valid  output  1  instr is valid for decode/execute.
REQ-011 SHALL have port advance  input  1  datapath finished current instruction; update PC.
REQ-012 SHALL have port branch  input  1  decoder branch flag.
REQ-013 SHALL have port mux_pc_branch  input  1  decoder: branch target selectable.
REQ-014 SHALL have port mux_branch_jump  input  1  decoder: 0 = jump (J/JAL), 1 = sequential/branch.
REQ-015 SHALL have port alu_zero  input  1  ALU condition result (ALU already inverts for BNE).
REQ-016 SHALL have port pc  output  32  current PC.
REQ-017 SHALL have port pc_plus4  output  32  pc+4, combinational, JAL link value.
REQ-018 SHALL have port fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, HOLD, ERROR.
REQ-020 IDLE SHALL transition to FETCH unconditionally on the next edge.
REQ-021 FETCH SHALL drive imem_req=1 and imem_addr=pc every cycle in the state.
REQ-022 FETCH with imem_ack=1 SHALL latch imem_rdata into instr, set instr_valid=1, clear the timeout counter, and go to HOLD (1-cycle latency from ack to instr_valid).
REQ-023 FETCH without imem_ack SHALL increment a 5-bit timeout counter; on reaching TIMEOUT-1 with no ack, it SHALL set fetch_err=1 and go to ERROR.
REQ-024 ERROR SHALL hold imem_req=0 and instr_valid=0, and SHALL be left only by reset.
REQ-025 HOLD SHALL keep instr and instr_valid=1 stable until advance=1.
REQ-026 HOLD with advance=1 SHALL load pc<=next_pc, clear instr_valid, and go to FETCH; control inputs and alu_zero are sampled in that same cycle.
REQ-027 next_pc SHALL be the jump target {pc_plus4[31:28], instr[25:0], 2'b00} when mux_branch_jump=0.
REQ-028 Otherwise, next_pc SHALL be pc_plus4 + (sign_extend(instr[15:0]) << 2) when branch & mux_pc_branch & alu_zero.
REQ-029 Otherwise, next_pc SHALL be pc_plus4.
REQ-030 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-031 pc[1:0] SHALL always be 2'b00.
REQ-032 advance outside HOLD and imem_ack outside FETCH SHALL be ignored.
REQ-033 Jump SHALL take priority over branch when both are indicated.

Reset
REQ-034 While nrst=0 at a rising edge: pc=RESET_PC, state=IDLE, imem_req=0, instr=32'h0 (NOP), instr_valid=0, fetch_err=0, counter=0.
REQ-035 Reset asserted mid-FETCH SHALL drop imem_req on that edge; a late imem_ack SHALL not be latched.

Structure
REQ-036 FSM state encoding, RESET_PC default and TIMEOUT default SHALL live in the shared CPU package.
REQ-037 Next-PC selection SHALL be a combinational sub-module, next_pc_sel.

Verification
REQ-038 Reset, ack after 2 wait cycles with rdata=32'h2008_0005 -> imem_addr=0, instr_valid at cycle 4, instr=32'h2008_0005; advance -> pc=4.
REQ-039 BEQ at pc=0x10, imm=16'hFFFE, branch=1, mux_pc_branch=1, alu_zero=1, advance -> pc=0x0C; with alu_zero=0 -> pc=0x14.
REQ-040 J with instr[25:0]=26'h000_0040 at pc=0x1000_0000 -> pc=0x1000_0100; pc_plus4=0x1000_0004 during HOLD.
REQ-041 No ack for 16 FETCH cycles -> fetch_err=1, imem_req=0; a later ack is ignored; nrst=0 clears fetch_err and pc=RESET_PC.
REQ-042 pc=32'hFFFF_FFFC, sequential advance -> pc=0.
REQ-043 nrst=0 asserted in FETCH with simultaneous imem_ack -> instr stays 0, instr_valid=0.
